// File: rtl/dc_gray_fifo_if.sv
// Byte-stream bundle for the dual-clock FIFO: write side lives in ft_clk, read side in mem_clk.
interface dc_gray_fifo_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          we;
  logic          full;
  logic [1:0]    wr_level;
  logic [DW-1:0] dout;
  logic          rd;
  logic          empty;
  logic [1:0]    rd_level;

  // A write is taken on the ft_clk edge where we & ~full; a read is taken on the mem_clk edge
  // where rd & ~empty, dout then holds the entry from the next cycle until the next taken read.
  modport master (
    output din, we, rd,
    input  full, wr_level, dout, empty, rd_level
  );
  modport slave (
    input  din, we, rd,
    output full, wr_level, dout, empty, rd_level
  );
endinterface

// File: rtl/dc_gray_fifo.sv
// Dual-clock byte FIFO (ft_clk writer -> mem_clk reader) with Gray-coded pointer crossings
// and coarse fill-level outputs for writer throttling.
module dc_gray_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          mem_clk,
  input  logic          ft_reset,
  input  logic          ft_clk,
  input  logic          clr,
  dc_gray_fifo_if.slave bus
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] HI_MARK = (AW + 1)'(3 << (AW - 2));

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
    return b;
  endfunction

  // Reset asserts at once in both domains and releases on each domain's own clock.
  logic [1:0] wrst_q, rrst_q, wclr_q, rclr_q;
  logic       wrst, rrst, wclr, rclr;

  always_ff @(posedge ft_clk or posedge ft_reset)
    if (ft_reset) wrst_q <= 2'b11;
    else          wrst_q <= {wrst_q[0], 1'b0};

  always_ff @(posedge mem_clk or posedge ft_reset)
    if (ft_reset) rrst_q <= 2'b11;
    else          rrst_q <= {rrst_q[0], 1'b0};

  assign wrst = wrst_q[1];
  assign rrst = rrst_q[1];

  always_ff @(posedge ft_clk or posedge wrst)
    if (wrst) wclr_q <= 2'b00;
    else      wclr_q <= {wclr_q[0], clr};

  always_ff @(posedge mem_clk or posedge rrst)
    if (rrst) rclr_q <= 2'b00;
    else      rclr_q <= {rclr_q[0], clr};

  assign wclr = wclr_q[1];
  assign rclr = rclr_q[1];

  logic [DW-1:0] mem [DEPTH];

  // ---------------- write domain (ft_clk) ----------------
  logic [AW:0] wp, wp_gray, rq1, rq2, occ_w;
  logic        full, wr_ok;

  assign full  = (wp_gray == {~rq2[AW:AW-1], rq2[AW-2:0]});
  assign wr_ok = bus.we && !full && !wclr && !wrst;

  always_ff @(posedge ft_clk or posedge wrst)
    if (wrst) begin
      wp      <= '0;
      wp_gray <= '0;
    end else if (wclr) begin
      wp      <= '0;
      wp_gray <= '0;
    end else if (wr_ok) begin
      wp      <= wp + 1'b1;
      wp_gray <= bin2gray(wp + 1'b1);
    end

  always_ff @(posedge ft_clk)
    if (wr_ok) mem[wp[AW-1:0]] <= bus.din;

  always_ff @(posedge ft_clk or posedge wrst)
    if (wrst) {rq2, rq1} <= '0;
    else      {rq2, rq1} <= {rq1, rp_gray};

  assign occ_w        = wp - gray2bin(rq2);
  assign bus.full     = full;
  assign bus.wr_level = (full || occ_w >= HI_MARK) ? 2'd3 : occ_w[AW-1:AW-2];

  // ---------------- read domain (mem_clk) ----------------
  logic [AW:0]   rp, rp_gray, wq1, wq2, occ_r;
  logic          empty, rd_ok;
  logic [DW-1:0] dout_q;
  logic [1:0]    rd_quarter;

  assign empty = (rp_gray == wq2);
  assign rd_ok = bus.rd && !empty && !rclr;

  always_ff @(posedge mem_clk or posedge rrst)
    if (rrst) begin
      rp      <= '0;
      rp_gray <= '0;
      dout_q  <= '0;
    end else if (rclr) begin
      rp      <= '0;
      rp_gray <= '0;
    end else if (rd_ok) begin
      dout_q  <= mem[rp[AW-1:0]];
      rp      <= rp + 1'b1;
      rp_gray <= bin2gray(rp + 1'b1);
    end

  always_ff @(posedge mem_clk or posedge rrst)
    if (rrst) {wq2, wq1} <= '0;
    else      {wq2, wq1} <= {wq1, wp_gray};

  // Read side reports free space, so the occupancy quarter is inverted.
  assign occ_r        = gray2bin(wq2) - rp;
  assign rd_quarter   = (occ_r >= HI_MARK) ? 2'd3 : occ_r[AW-1:AW-2];
  assign bus.rd_level = ~rd_quarter;
  assign bus.empty    = empty;
  assign bus.dout     = dout_q;
endmodule

// File: tb/tb_dc_gray_fifo.sv
// Bench for dc_gray_fifo: queue model of accepted bytes checked every mem_clk cycle, plus
// directed phases with literal expectations for reset, levels, fill, stream, reset and clear.
module tb_dc_gray_fifo;
  localparam int DW = 8;

  logic mem_clk  = 1'b0;
  logic ft_clk   = 1'b0;
  logic ft_reset = 1'b0;
  logic clr      = 1'b0;

  dc_gray_fifo_if #(.DW(DW)) bus ();

  dc_gray_fifo #(.DW(DW), .AW(4)) dut (
    .mem_clk (mem_clk),
    .ft_reset(ft_reset),
    .ft_clk  (ft_clk),
    .clr     (clr),
    .bus     (bus)
  );

  // ---------------- clock/reset ----------------
  always #5 mem_clk = ~mem_clk;
  always #8 ft_clk  = ~ft_clk;

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] dout_m = '0;
  bit            pend = 1'b0;
  bit            skip_empty = 1'b0;
  logic [DW-1:0] stream [40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: dout is the byte last popped from the queue of accepted writes; with nothing
  // outstanding the reader must see empty.
  always @(negedge mem_clk) begin
    if (ft_reset) begin
      dout_m = '0;
      pend   = 1'b0;
    end
    check("dout_vs_model", bus.dout, dout_m);
    if (pend) begin
      got_q.push_back(bus.dout);
      pend = 1'b0;
    end
    if (!skip_empty && exp_q.size() == 0) check("empty_when_model_empty", bus.empty, 1);
    if (!ft_reset && bus.rd && !bus.empty) begin
      if (exp_q.size() == 0) check("read_underflow", 1, 0);
      else begin
        dout_m = exp_q.pop_front();
        pend   = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [DW-1:0] b, input bit throttle);
    int n = 0;
    @(posedge ft_clk); #1;
    bus.we = 1'b0;
    while ((bus.full || (throttle && bus.wr_level == 2'd3)) && n < 200) begin
      @(posedge ft_clk); #1;
      n++;
    end
    if (n >= 200) check("wr_timeout", n, 0);
    else begin
      bus.din = b;
      bus.we  = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic wr_end();
    @(posedge ft_clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic wr_drop(input logic [DW-1:0] b);
    @(posedge ft_clk); #1;
    check("full_before_drop", bus.full, 1);
    bus.din = b;
    bus.we  = 1'b1;
    wr_end();
  endtask

  task automatic rd_n(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 3000) begin
      @(posedge mem_clk); #1;
      if (!bus.empty) begin
        bus.rd = 1'b1;
        got++;
      end else bus.rd = 1'b0;
      t++;
    end
    @(posedge mem_clk); #1;
    bus.rd = 1'b0;
    @(negedge mem_clk); #1;
    if (got < n) check("rd_timeout", got, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ft_clk);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_empty"},    bus.empty, 1);
    check({tag, "_full"},     bus.full, 0);
    check({tag, "_wr_level"}, bus.wr_level, 0);
    check({tag, "_rd_level"}, bus.rd_level, 3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bus.din = '0;
    bus.we  = 1'b0;
    bus.rd  = 1'b0;
    for (int i = 0; i < 8; i++) stream[i] = '0;
    stream[0] = 8'h08; stream[2] = 8'h55; stream[3] = 8'hAA; stream[4] = 8'd16;
    for (int i = 8; i < 40; i++) stream[i] = DW'(i - 8);

    // reset
    #1 ft_reset = 1'b1;
    #60;
    check_idle_outputs("reset");
    check("reset_dout", bus.dout, 0);
    ft_reset = 1'b0;
    idle(4);
    check_idle_outputs("post_reset");

    // single byte and empty fall latency
    wr(8'hA5, 1'b0);
    wr_end();
    k = 0;
    while (bus.empty && k < 6) begin
      @(posedge mem_clk); #1;
      k++;
    end
    check("empty_fall_2to3_edges", (k >= 2 && k <= 3), 1);
    rd_n(1);
    check("single_count", got_q.size(), 1);
    if (got_q.size() > 0) check("single_data", got_q.pop_front(), 8'hA5);
    check("single_empty_after", bus.empty, 1);
    got_q.delete();

    // levels at 4 / 8 / 12 entries
    for (int i = 0; i < 4; i++) wr(DW'(8'h10 + i), 1'b0);
    wr_end(); idle(4);
    check("lvl4_wr", bus.wr_level, 1);
    check("lvl4_rd", bus.rd_level, 2);
    for (int i = 4; i < 8; i++) wr(DW'(8'h10 + i), 1'b0);
    wr_end(); idle(4);
    check("lvl8_wr", bus.wr_level, 2);
    check("lvl8_rd", bus.rd_level, 1);
    for (int i = 8; i < 12; i++) wr(DW'(8'h10 + i), 1'b0);
    wr_end(); idle(4);
    check("lvl12_wr", bus.wr_level, 3);
    check("lvl12_rd", bus.rd_level, 0);
    check("lvl12_full", bus.full, 0);
    rd_n(12);
    check("lvl_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) check("lvl_data", got_q[i], 8'h10 + i);
    got_q.delete();
    idle(4);

    // fill to 16, drop the 17th, drain in order
    for (int i = 0; i < 16; i++) wr(DW'(i), 1'b0);
    wr_end(); idle(4);
    check("fill_full", bus.full, 1);
    check("fill_wr_level", bus.wr_level, 3);
    check("fill_rd_level", bus.rd_level, 0);
    wr_drop(8'hFF);
    idle(2);
    check("fill_still_full", bus.full, 1);
    rd_n(16);
    check("fill_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) check("fill_data", got_q[i], i);
    got_q.delete();
    idle(4);
    check_idle_outputs("after_drain");

    // throttled stream with concurrent reader
    fork
      begin
        for (int i = 0; i < 40; i++) wr(stream[i], 1'b1);
        wr_end();
      end
      rd_n(40);
    join
    check("stream_count", got_q.size(), 40);
    for (int i = 0; i < 40 && i < got_q.size(); i++) check("stream_data", got_q[i], stream[i]);
    got_q.delete();
    idle(4);

    // reset mid-operation with 6 entries held
    for (int i = 0; i < 6; i++) wr(DW'(8'h60 + i), 1'b0);
    wr_end(); idle(4);
    check("pre_reset_empty", bus.empty, 0);
    #3;
    ft_reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_empty", bus.empty, 1);
    check("midrst_full", bus.full, 0);
    #40;
    ft_reset = 1'b0;
    idle(4);
    check_idle_outputs("midrst_release");
    wr(8'h3C, 1'b0);
    wr_end();
    rd_n(1);
    check("midrst_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("midrst_next_data", got_q.pop_front(), 8'h3C);
    got_q.delete();

    // synchronous clear with 5 entries held
    for (int i = 0; i < 5; i++) wr(DW'(8'h70 + i), 1'b0);
    wr_end(); idle(4);
    skip_empty = 1'b1;
    exp_q.delete();
    clr = 1'b1;
    idle(6);
    clr = 1'b0;
    idle(6);
    skip_empty = 1'b0;
    check_idle_outputs("after_clr");
    check("clr_dout_held", bus.dout, 8'h3C);
    wr(8'h77, 1'b0);
    wr_end();
    rd_n(1);
    check("clr_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("clr_next_data", got_q.pop_front(), 8'h77);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    check("global_timeout", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
